// File: rtl/sram_fifo_param.sv
// Parametrised single-clock FIFO over an inferred SRAM array with a registered read port,
// fill level, almost-full/almost-empty thresholds and sticky overflow/underflow flags.
module sram_fifo_param #(
    parameter  int DATA_W    = 8,
    parameter  int DEPTH     = 16,
    parameter  int AFULL_TH  = 14,
    parameter  int AEMPTY_TH = 2,
    localparam int ADDR_W    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              write,
    input  logic [DATA_W-1:0] data_in,
    input  logic              read,
    input  logic              clr_err,
    output logic [DATA_W-1:0] data_out,
    output logic              valid,
    output logic              ready,
    output logic              full,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   level,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1);
    localparam logic [ADDR_W:0]   LVL_ONE    = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0]   LVL_FULL   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   LVL_AFULL  = (ADDR_W + 1)'(AFULL_TH);
    localparam logic [ADDR_W:0]   LVL_AEMPTY = (ADDR_W + 1)'(AEMPTY_TH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_level;
    logic [DATA_W-1:0] r_data_out;
    logic              r_valid;
    logic              r_overflow;
    logic              r_underflow;

    logic w_wr_en;
    logic w_rd_en;

    // Status flags decode the registered level only, so acceptance never depends on same-cycle requests.
    assign ready        = (r_level != '0);
    assign full         = (r_level == LVL_FULL);
    assign almost_full  = (r_level >= LVL_AFULL);
    assign almost_empty = (r_level <= LVL_AEMPTY);

    assign w_wr_en = write && !full;
    assign w_rd_en = read && ready;

    // NOTE: the storage array has no reset; a word is only ever read after it has been written.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    // NOTE: non-blocking assignments keep every register sampling pre-edge values, so order here is irrelevant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_data_out  <= '0;
            r_valid     <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end

            r_valid <= w_rd_en;
            if (w_rd_en) begin
                r_data_out <= r_mem[r_rd_ptr];
                r_rd_ptr   <= r_rd_ptr + PTR_ONE;
            end

            unique case ({w_wr_en, w_rd_en})
                2'b10:   r_level <= r_level + LVL_ONE;
                2'b01:   r_level <= r_level - LVL_ONE;
                default: r_level <= r_level;
            endcase

            // A new error event wins over a clear arriving on the same edge.
            if (write && full) begin
                r_overflow <= 1'b1;
            end else if (clr_err) begin
                r_overflow <= 1'b0;
            end

            if (read && !ready) begin
                r_underflow <= 1'b1;
            end else if (clr_err) begin
                r_underflow <= 1'b0;
            end
        end
    end

    assign data_out  = r_data_out;
    assign valid     = r_valid;
    assign level     = r_level;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule

// File: tb/tb_sram_fifo_param.sv
// Directed bench for sram_fifo_param (DEPTH=16, DATA_W=8): a vector table for the main
// fill/drain/error sequences plus hand-written wrap and asynchronous-reset sequences.
module tb_sram_fifo_param;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              write;
    logic [DATA_W-1:0] data_in;
    logic              read;
    logic              clr_err;
    logic [DATA_W-1:0] data_out;
    logic              valid;
    logic              ready;
    logic              full;
    logic              almost_full;
    logic              almost_empty;
    logic [4:0]        level;
    logic              overflow;
    logic              underflow;

    int total = 0;
    int bad   = 0;

    sram_fifo_param #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .AFULL_TH (14),
        .AEMPTY_TH(2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .write       (write),
        .data_in     (data_in),
        .read        (read),
        .clr_err     (clr_err),
        .data_out    (data_out),
        .valid       (valid),
        .ready       (ready),
        .full        (full),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .level       (level),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       wr;
        logic       rd;
        logic       clr;
        logic [7:0] din;
        int         lvl;
        logic [7:0] dout;
        logic       vld;
        logic       ovf;
        logic       unf;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(logic wr, logic rd, logic clr, logic [7:0] din,
                                int lvl, logic [7:0] dout, logic vld, logic ovf, logic unf);
        vec_t v;
        v.wr = wr; v.rd = rd; v.clr = clr; v.din = din;
        v.lvl = lvl; v.dout = dout; v.vld = vld; v.ovf = ovf; v.unf = unf;
        vecs.push_back(v);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_state(string tag, int lvl, logic [7:0] dout, logic vld, logic ovf, logic unf);
        check({tag, ".level"},        32'(level),        32'(lvl));
        check({tag, ".ready"},        32'(ready),        32'(lvl != 0));
        check({tag, ".full"},         32'(full),         32'(lvl == 16));
        check({tag, ".almost_full"},  32'(almost_full),  32'(lvl >= 14));
        check({tag, ".almost_empty"}, 32'(almost_empty), 32'(lvl <= 2));
        check({tag, ".data_out"},     32'(data_out),     32'(dout));
        check({tag, ".valid"},        32'(valid),        32'(vld));
        check({tag, ".overflow"},     32'(overflow),     32'(ovf));
        check({tag, ".underflow"},    32'(underflow),    32'(unf));
    endtask

    task automatic step(logic w, logic r, logic c, logic [7:0] d);
        write   = w;
        read    = r;
        clr_err = c;
        data_in = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] q[$];
        logic [7:0] exp_dout;
        logic [7:0] tail[5];
        logic [7:0] seq;

        // Fill, overflow, drain and error-flag sequences.
        for (int i = 0; i < 16; i++) add(1, 0, 0, 8'hE0 + 8'(i), i + 1, 8'h00, 0, 0, 0);
        add(1, 0, 0, 8'hF0, 16, 8'h00, 0, 1, 0);
        for (int k = 0; k < 16; k++) add(0, 1, 0, 8'h00, 15 - k, 8'hE0 + 8'(k), 1, 1, 0);
        add(0, 1, 0, 8'h00, 0, 8'hEF, 0, 1, 1);
        add(0, 0, 1, 8'h00, 0, 8'hEF, 0, 0, 0);
        add(0, 1, 1, 8'h00, 0, 8'hEF, 0, 0, 1);
        add(0, 0, 1, 8'h00, 0, 8'hEF, 0, 0, 0);
        // Concurrent read+write at level 5, then drain in FIFO order.
        for (int i = 0; i < 5; i++) add(1, 0, 0, 8'h50 + 8'(i), i + 1, 8'hEF, 0, 0, 0);
        for (int i = 0; i < 4; i++) add(1, 1, 0, 8'hA5 + 8'(i), 5, 8'h50 + 8'(i), 1, 0, 0);
        tail = '{8'h54, 8'hA5, 8'hA6, 8'hA7, 8'hA8};
        for (int i = 0; i < 5; i++) add(0, 1, 0, 8'h00, 4 - i, tail[i], 1, 0, 0);
        // Concurrent read+write when empty and when full.
        add(1, 1, 0, 8'h11, 1, 8'hA8, 0, 0, 1);
        add(0, 0, 1, 8'h00, 1, 8'hA8, 0, 0, 0);
        for (int i = 0; i < 15; i++) add(1, 0, 0, 8'h60 + 8'(i), 2 + i, 8'hA8, 0, 0, 0);
        add(1, 1, 0, 8'h22, 15, 8'h11, 1, 1, 0);
        add(0, 0, 1, 8'h00, 15, 8'h11, 0, 0, 0);
        for (int i = 0; i < 15; i++) add(0, 1, 0, 8'h00, 14 - i, 8'h60 + 8'(i), 1, 0, 0);

        rst_n   = 1'b0;
        write   = 1'b0;
        read    = 1'b0;
        clr_err = 1'b0;
        data_in = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_state("reset", 0, 8'h00, 0, 0, 0);

        foreach (vecs[i]) begin
            step(vecs[i].wr, vecs[i].rd, vecs[i].clr, vecs[i].din);
            check_state($sformatf("vec%0d", i), vecs[i].lvl, vecs[i].dout, vecs[i].vld,
                        vecs[i].ovf, vecs[i].unf);
        end

        // Pointer wrap against a reference queue: write 10, read 10, write 12, read 12.
        exp_dout = 8'h6E;
        seq      = 8'h80;
        for (int phase = 0; phase < 4; phase++) begin
            int n;
            n = (phase < 2) ? 10 : 12;
            for (int j = 0; j < n; j++) begin
                logic exp_vld;
                exp_vld = 1'b0;
                if (phase % 2 == 0) begin
                    step(1, 0, 0, seq);
                    q.push_back(seq);
                    seq = seq + 8'd1;
                end else begin
                    step(0, 1, 0, 8'h00);
                    exp_dout = q.pop_front();
                    exp_vld  = 1'b1;
                end
                check_state($sformatf("wrap%0d_%0d", phase, j), q.size(), exp_dout, exp_vld, 0, 0);
            end
        end

        // Asynchronous reset between clock edges at level 7.
        for (int i = 0; i < 7; i++) step(1, 0, 0, 8'h70 + 8'(i));
        check("pre_reset.level", 32'(level), 32'd7);
        write = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_state("async_reset", 0, 8'h00, 0, 0, 0);
        #1;
        rst_n = 1'b1;
        step(1, 0, 0, 8'h3C);
        check_state("post_reset_wr", 1, 8'h00, 0, 0, 0);
        step(0, 1, 0, 8'h00);
        check_state("post_reset_rd", 0, 8'h3C, 1, 0, 0);
        step(0, 0, 0, 8'h00);
        check_state("post_reset_idle", 0, 8'h3C, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
